sort_out_ser: RTL and testbench
===============================

SORT_OUT_SER -- requirements
Module: sort_out_ser

Interface
REQ-001 Parameter W_DATA, default 8, width of one sorted element.
REQ-002 Parameter NUM, default 32, elements per frame; shall be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all flops on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 vld_in  input  1  one-cycle pulse; din carries a complete sorted frame (upstream sorter vld_out).
REQ-006 din  input  NUM*W_DATA  flattened frame; element k occupies bits [k*W_DATA +: W_DATA]; element 0 is the smallest.
REQ-007 dout_vld  output  1  dout holds a valid element.
REQ-008 dout_rdy  input  1  downstream accepts; transfer occurs when dout_vld and dout_rdy are both high.
REQ-009 dout  output  W_DATA  current element.
REQ-010 dout_idx  output  log2(NUM)  index of the current element within its frame.
REQ-011 dout_last  output  1  high with element NUM-1.
REQ-012 ovf  output  1  one-cycle pulse when an incoming frame is dropped.
REQ-013 drop_cnt  output  8  count of dropped frames; saturates at 255.
REQ-014 busy  output  1  high when at least one frame is buffered or being sent.

Function
REQ-015 The block shall hold two frame slots in a ping-pong buffer; a write pointer, a read pointer and per-slot full flags shall track occupancy.
REQ-016 On vld_in with a free slot, din shall be captured into the slot at the write pointer, and the write pointer shall toggle.
REQ-017 On vld_in with both slots full, the frame shall be discarded, ovf shall pulse in the next cycle, and drop_cnt shall increment (saturating).
REQ-018 The output FSM shall have two states: IDLE (dout_vld=0) and SEND (dout_vld=1).
REQ-019 IDLE -> SEND shall occur in the cycle after the read slot becomes full; first-element latency from vld_in into an empty block is 1 cycle.
REQ-020 In SEND, elements shall be emitted in ascending index order 0..NUM-1 from the read slot; dout_idx advances only on a transfer.
REQ-021 While dout_vld=1 and dout_rdy=0, dout, dout_idx and dout_last shall remain stable.
REQ-022 When element NUM-1 transfers, the read slot shall be freed and the read pointer toggled; if the other slot is full, the FSM shall stay in SEND with index 0 next cycle (no bubble), otherwise it goes to IDLE.
REQ-023 If the last element transfers in the same cycle that vld_in arrives with both slots full, the freed slot shall accept the new frame (no drop).
REQ-024 With dout_rdy held high, sustained throughput shall be one element per cycle; vld_in spacing of at least NUM cycles shall never drop.
REQ-025 dout shall read 0 while dout_vld=0.
REQ-026 busy shall equal the OR of the slot full flags.

Reset
REQ-027 rst shall have priority over all other inputs; a frame in progress is abandoned and vld_in is ignored in that cycle.
REQ-028 Reset values: dout_vld=0, dout=0, dout_idx=0, dout_last=0, ovf=0, drop_cnt=0, busy=0; FSM=IDLE, both pointers=0, full flags=0.
REQ-029 Slot data storage does not require reset.

Structure
REQ-030 A shared package sort_pkg shall hold W_DATA, NUM, the derived index width IDX_W=$clog2(NUM), and the FSM state enumeration.
REQ-031 One sub-module, sort_frame_slot, shall implement a single frame register with load enable and an element read mux; it is instantiated twice.
REQ-032 Estimated size is 150-300 RTL lines.

Verification
REQ-033 After reset, one frame with din element k=k and dout_rdy=1 -> dout_vld rises 1 cycle after vld_in; dout=0..31 on 32 consecutive cycles; dout_last only with dout=31; busy then drops.
REQ-034 Same frame with dout_rdy toggling 1,0 -> each element held while rdy=0; 32 transfers total; no duplicates or losses.
REQ-035 Three vld_in pulses 1 cycle apart with dout_rdy=1 -> frames 1 and 2 output back-to-back with no bubble; frame 3 dropped; one ovf pulse; drop_cnt=1.
REQ-036 Two frames buffered, then a third vld_in in the exact cycle the last element of frame 1 transfers -> third frame accepted; ovf=0; 96 elements output.
REQ-037 rst asserted for 1 cycle at element 10 of a frame, with vld_in high in the same cycle -> all outputs return to reset values next cycle; that vld_in is ignored.
REQ-038 dout_rdy=0 and 260 vld_in pulses -> drop_cnt saturates at 255; ovf pulses 258 times.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared constants for the sorted-frame output serializer.
package sort_pkg;

    localparam int W_DATA = 8;
    localparam int NUM    = 32;
    localparam int IDX_W  = $clog2(NUM);

    // Output FSM state encoding.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

endpackage

// File: rtl/sort_frame_slot.sv
// One frame register of the ping-pong buffer: parallel load, element read mux.
module sort_frame_slot #(
    parameter int W_DATA = sort_pkg::W_DATA,
    parameter int NUM    = sort_pkg::NUM,
    parameter int IDX_W  = $clog2(NUM)
) (
    input  logic                    clk,
    input  logic                    load,
    input  logic [NUM*W_DATA-1:0]   din,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [W_DATA-1:0]       rd_data
);

    logic [NUM*W_DATA-1:0] frame_q;

    // Capture a whole sorted frame when the parent selects this slot.
    // NOTE: the frame storage has no reset on purpose; the parent's full flags
    // say when its contents are meaningful, so reset would only add load.
    always_ff @(posedge clk) begin
        if (load) begin
            frame_q <= din;
        end
    end

    assign rd_data = frame_q[rd_idx*W_DATA +: W_DATA];

endmodule

// File: rtl/sort_out_ser.sv
// Serializes complete sorted frames one element per transfer, with a two-slot
// ping-pong buffer so a new frame can arrive while the previous one drains.
module sort_out_ser
    import sort_pkg::*;
#(
    parameter int W_DATA = sort_pkg::W_DATA,
    parameter int NUM    = sort_pkg::NUM
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vld_in,
    input  logic [NUM*W_DATA-1:0]   din,
    output logic                    dout_vld,
    input  logic                    dout_rdy,
    output logic [W_DATA-1:0]       dout,
    output logic [$clog2(NUM)-1:0]  dout_idx,
    output logic                    dout_last,
    output logic                    ovf,
    output logic [7:0]              drop_cnt,
    output logic                    busy
);

    localparam int                  IDX_BITS = $clog2(NUM);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM - 1);

    logic [0:0]          state, state_n;
    logic                wr_ptr, rd_ptr, rd_n;
    logic [1:0]          full, full_n;
    logic [IDX_BITS-1:0] idx;
    logic                ovf_q;
    logic [7:0]          drop_q;

    logic                xfer, last_xfer, accept, drop;
    logic [W_DATA-1:0]   slot0_rd, slot1_rd;

    assign xfer      = (state == ST_SEND) && dout_rdy;
    assign last_xfer = xfer && (idx == LAST_IDX);
    // A full buffer still takes a frame when the read slot empties this cycle;
    // in that case both pointers point at the slot being freed.
    assign accept    = vld_in && (!full[wr_ptr] || (last_xfer && (wr_ptr == rd_ptr)));
    assign drop      = vld_in && !accept;
    assign rd_n      = rd_ptr ^ last_xfer;

    // Next occupancy and next FSM state; SEND whenever the next read slot holds a frame.
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        full_n = full;
        if (last_xfer) begin
            full_n[rd_ptr] = 1'b0;
        end
        if (accept) begin
            full_n[wr_ptr] = 1'b1;
        end
        state_n = ST_IDLE;
        case (state)
            ST_IDLE: state_n = full_n[rd_n] ? ST_SEND : ST_IDLE;
            ST_SEND: state_n = full_n[rd_n] ? ST_SEND : ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Pointers, full flags, FSM and element index; reset wins over everything.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            full   <= 2'b00;
            idx    <= '0;
        end else begin
            state  <= state_n;
            wr_ptr <= wr_ptr ^ accept;
            rd_ptr <= rd_n;
            full   <= full_n;
            if (last_xfer) begin
                idx <= '0;
            end else if (xfer) begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Overflow pulse and saturating dropped-frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            drop_q <= 8'd0;
        end else begin
            ovf_q <= drop;
            if (drop && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    sort_frame_slot #(
        .W_DATA (W_DATA),
        .NUM    (NUM),
        .IDX_W  (IDX_BITS)
    ) u_slot0 (
        .clk     (clk),
        .load    (accept && !rst && !wr_ptr),
        .din     (din),
        .rd_idx  (idx),
        .rd_data (slot0_rd)
    );

    sort_frame_slot #(
        .W_DATA (W_DATA),
        .NUM    (NUM),
        .IDX_W  (IDX_BITS)
    ) u_slot1 (
        .clk     (clk),
        .load    (accept && !rst && wr_ptr),
        .din     (din),
        .rd_idx  (idx),
        .rd_data (slot1_rd)
    );

    assign dout_vld  = (state == ST_SEND);
    assign dout      = dout_vld ? (rd_ptr ? slot1_rd : slot0_rd) : '0;
    assign dout_idx  = idx;
    assign dout_last = dout_vld && (idx == LAST_IDX);
    assign ovf       = ovf_q;
    assign drop_cnt  = drop_q;
    assign busy      = |full;

endmodule

// File: tb/tb_sort_out_ser.sv
// Self-checking bench for sort_out_ser: directed table, corner-case sequences
// and randomized traffic against a frame-queue reference model.
module tb_sort_out_ser;

    localparam int W   = 8;
    localparam int NUM = 32;
    localparam int IW  = 5;
    localparam int FW  = NUM * W;

    logic          clk = 1'b0;
    logic          rst, vld_in, dout_rdy;
    logic [FW-1:0] din;
    logic          dout_vld, dout_last, ovf, busy;
    logic [W-1:0]  dout;
    logic [IW-1:0] dout_idx;
    logic [7:0]    drop_cnt;

    always #5 clk = ~clk;

    sort_out_ser #(.W_DATA(W), .NUM(NUM)) dut (
        .clk       (clk),
        .rst       (rst),
        .vld_in    (vld_in),
        .din       (din),
        .dout_vld  (dout_vld),
        .dout_rdy  (dout_rdy),
        .dout      (dout),
        .dout_idx  (dout_idx),
        .dout_last (dout_last),
        .ovf       (ovf),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_xfer;
    int n_ovf;
    logic [W-1:0] got[$];

    // Reference model: queue of buffered frames, position within the head frame.
    logic [FW-1:0] m_q[$];
    int            m_pos  = 0;
    logic          m_ovf  = 1'b0;
    int            m_drop = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        for (int k = 0; k < NUM; k++) f[k*W +: W] = 8'($urandom);
        return f;
    endfunction

    task automatic model_update(input logic v, input logic r, input logic rs, input logic [FW-1:0] d);
        bit xfer, last, room;
        if (rs) begin
            m_q.delete();
            m_pos  = 0;
            m_ovf  = 1'b0;
            m_drop = 0;
            return;
        end
        xfer  = (m_q.size() != 0) && r;
        last  = xfer && (m_pos == NUM - 1);
        room  = (m_q.size() - (last ? 1 : 0)) < 2;
        m_ovf = v && !room;
        if (m_ovf && m_drop < 255) m_drop++;
        if (last) begin
            void'(m_q.pop_front());
            m_pos = 0;
        end else if (xfer) begin
            m_pos++;
        end
        if (v && room) m_q.push_back(d);
    endtask

    task automatic model_check();
        bit            ev;
        logic [FW-1:0] f;
        logic [W-1:0]  ed;
        ev = (m_q.size() != 0);
        ed = '0;
        if (ev) begin
            f  = m_q[0];
            ed = f[m_pos*W +: W];
        end
        check("m_dout_vld",  dout_vld,  ev);
        check("m_dout",      dout,      ed);
        check("m_dout_idx",  dout_idx,  ev ? m_pos : 0);
        check("m_dout_last", dout_last, ev && (m_pos == NUM - 1));
        check("m_ovf",       ovf,       m_ovf);
        check("m_drop_cnt",  drop_cnt,  m_drop);
        check("m_busy",      busy,      ev);
    endtask

    // Apply one cycle of inputs (called at the falling edge), then check at the next falling edge.
    task automatic step(input logic v, input logic r, input logic rs, input logic [FW-1:0] d);
        vld_in   = v;
        dout_rdy = r;
        rst      = rs;
        din      = d;
        if (dout_vld && r && !rs) begin
            n_xfer++;
            got.push_back(dout);
        end
        model_update(v, r, rs, d);
        @(posedge clk);
        @(negedge clk);
        if (ovf) n_ovf++;
        model_check();
    endtask

    task automatic clear_counts();
        n_xfer = 0;
        n_ovf  = 0;
        got.delete();
    endtask

    typedef struct {
        logic       rs, v, r;
        logic       e_vld;
        logic [7:0] e_dout;
        logic [4:0] e_idx;
        logic       e_last, e_busy;
    } vec_t;

    vec_t          tbl[7];
    logic [FW-1:0] ramp;
    logic [FW-1:0] fa, fb, fc;
    bit            found;
    int            errs;

    initial begin
        for (int k = 0; k < NUM; k++) ramp[k*W +: W] = 8'(k);
        rst = 1'b1; vld_in = 1'b0; dout_rdy = 1'b0; din = '0;
        clear_counts();

        // rst, vld, rdy -> expected outputs in the following cycle
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 5'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 5'd0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 5'd1, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 5'd1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd2, 5'd2, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 5'd0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 5'd0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].v, tbl[i].r, tbl[i].rs, ramp);
            check($sformatf("tbl%0d_vld", i),  dout_vld,  tbl[i].e_vld);
            check($sformatf("tbl%0d_dout", i), dout,      tbl[i].e_dout);
            check($sformatf("tbl%0d_idx", i),  dout_idx,  tbl[i].e_idx);
            check($sformatf("tbl%0d_last", i), dout_last, tbl[i].e_last);
            check($sformatf("tbl%0d_busy", i), busy,      tbl[i].e_busy);
            check($sformatf("tbl%0d_ovf", i),  ovf,       1'b0);
        end

        // Full ramp frame with rdy held high: 0..31 on consecutive cycles.
        step(1'b0, 1'b0, 1'b1, '0);
        step(1'b1, 1'b1, 1'b0, ramp);
        for (int i = 0; i < NUM; i++) begin
            check("ramp_dout", dout, i);
            check("ramp_last", dout_last, i == NUM - 1);
            step(1'b0, 1'b1, 1'b0, '0);
        end
        check("ramp_busy_end", busy, 1'b0);

        // rdy toggling 1,0: every element once, in order.
        step(1'b0, 1'b0, 1'b1, '0);
        clear_counts();
        step(1'b1, 1'b1, 1'b0, ramp);
        for (int i = 0; i < 200 && busy; i++) step(1'b0, (i % 2) == 0, 1'b0, '0);
        check("toggle_count", got.size(), NUM);
        errs = 0;
        for (int i = 0; i < got.size(); i++) if (got[i] != 8'(i)) errs++;
        check("toggle_order", errs, 0);

        // Three back-to-back frames: two drain with no bubble, the third drops.
        step(1'b0, 1'b0, 1'b1, '0);
        clear_counts();
        step(1'b1, 1'b1, 1'b0, rand_frame());
        step(1'b1, 1'b1, 1'b0, rand_frame());
        step(1'b1, 1'b1, 1'b0, rand_frame());
        check("b2b_ovf_now", ovf, 1'b1);
        for (int i = 0; i < 2 * NUM - 2; i++) step(1'b0, 1'b1, 1'b0, '0);
        check("b2b_xfers", n_xfer, 2 * NUM);
        check("b2b_done", dout_vld, 1'b0);
        check("b2b_ovf_pulses", n_ovf, 1);
        check("b2b_drop_cnt", drop_cnt, 1);

        // Third frame arrives exactly when the last element of frame 1 transfers.
        step(1'b0, 1'b0, 1'b1, '0);
        clear_counts();
        fa = rand_frame(); fb = rand_frame(); fc = rand_frame();
        step(1'b1, 1'b1, 1'b0, fa);
        step(1'b1, 1'b1, 1'b0, fb);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (dout_vld && dout_last) begin
                found = 1;
                break;
            end
            step(1'b0, 1'b1, 1'b0, '0);
        end
        check("edge_found_last", found, 1'b1);
        step(1'b1, 1'b1, 1'b0, fc);
        check("edge_ovf", ovf, 1'b0);
        for (int i = 0; i < 200 && busy; i++) step(1'b0, 1'b1, 1'b0, '0);
        check("edge_xfers", n_xfer, 3 * NUM);
        check("edge_drop_cnt", drop_cnt, 0);
        check("edge_ovf_pulses", n_ovf, 0);

        // Reset mid-frame at element 10 together with vld_in.
        step(1'b0, 1'b0, 1'b1, '0);
        step(1'b1, 1'b1, 1'b0, ramp);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, '0);
        check("rst10_idx", dout_idx, 10);
        step(1'b1, 1'b1, 1'b1, ramp);
        check("rst10_vld", dout_vld, 1'b0);
        check("rst10_idx0", dout_idx, 0);
        check("rst10_busy", busy, 1'b0);
        step(1'b0, 1'b1, 1'b0, '0);
        check("rst10_still_idle", dout_vld, 1'b0);

        // Stalled output, 260 frames: counter saturates.
        step(1'b0, 1'b0, 1'b1, '0);
        clear_counts();
        for (int i = 0; i < 260; i++) step(1'b1, 1'b0, 1'b0, rand_frame());
        step(1'b0, 1'b0, 1'b0, '0);
        check("sat_ovf_pulses", n_ovf, 258);
        check("sat_drop_cnt", drop_cnt, 255);

        // Randomized traffic against the model.
        step(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 75,
                 $urandom_range(0, 999) == 0, rand_frame());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
